// File: rtl/rtc_3wire_responder_if.sv
// Pin-level view of the 3-wire RTC bus, plus the write-report strobe and status outputs.
// wr_stb has no backpressure: wr_ram/wr_addr/wr_data are meaningful only in the cycle wr_stb is 1.
interface rtc_3wire_responder_if;
    logic       rtc_reset_n;
    logic       rtc_sclk;
    logic       rtc_data_in;
    logic       rtc_data_out;
    logic       rtc_data_oe;
    logic       wr_stb;
    logic       wr_ram;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       cmd_err;
    logic       busy;
    logic [2:0] dbg_state;

    modport slave (
        input  rtc_reset_n, rtc_sclk, rtc_data_in,
        output rtc_data_out, rtc_data_oe, wr_stb, wr_ram, wr_addr, wr_data,
        output cmd_err, busy, dbg_state
    );

    modport master (
        output rtc_reset_n, rtc_sclk, rtc_data_in,
        input  rtc_data_out, rtc_data_oe, wr_stb, wr_ram, wr_addr, wr_data,
        input  cmd_err, busy, dbg_state
    );
endinterface

// File: rtl/rtc_3wire_responder.sv
// Far-end responder of the 3-wire serial RTC bus: command decode, single/burst
// reads and writes against an 8-entry clock-register bank and a RAM bank.
module rtc_3wire_responder #(
    parameter int RAM_DEPTH   = 31,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLOCKINPUT,
    input  logic                  PLD_RESET_N,
    rtc_3wire_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [4:0] BURST_ADDR  = 5'h1F;
    localparam logic [4:0] RAM_LAST    = 5'(RAM_DEPTH - 1);
    localparam logic [5:0] RAM_DEPTH_W = 6'(RAM_DEPTH);

    // ---------------- synchronizers and edge detect ----------------
    logic [SYNC_STAGES-1:0] ce_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   ce_prev_q;
    logic                   sclk_prev_q;
    logic [SYNC_STAGES:0]   settle_q;

    logic ce_s, sclk_s, data_s;
    logic ce_rise, ce_fall, sclk_rise, sclk_fall;

    always_ff @(posedge CLOCKINPUT) begin
        if (!PLD_RESET_N) begin
            ce_sync_q   <= '0;
            sclk_sync_q <= '0;
            data_sync_q <= '0;
            ce_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            settle_q    <= '0;
        end else begin
            ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], bus.rtc_reset_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.rtc_sclk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.rtc_data_in};
            ce_prev_q   <= ce_s;
            sclk_prev_q <= sclk_s;
            settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign ce_s      = ce_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign ce_rise   = ce_s & ~ce_prev_q;
    assign ce_fall   = ~ce_s & ce_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // ---------------- storage ----------------
    logic [7:0] clk_q [0:7];
    logic [7:0] ram_q [0:RAM_DEPTH-1];

    // ---------------- FSM and datapath registers ----------------
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       is_ram_q, is_ram_d;
    logic       burst_q, burst_d;
    logic [4:0] addr_q, addr_d;
    logic       armed_q, armed_d;
    logic       dout_q, dout_d;
    logic       oe_q, oe_d;
    logic       wr_stb_q, wr_stb_d;
    logic       wr_ram_q, wr_ram_d;
    logic [4:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       cmd_err_q, cmd_err_d;
    logic       busy_q;

    logic [7:0] in_byte;
    logic [7:0] rd_byte;
    logic       last_byte;
    logic       wr_ok;
    logic       we;
    logic       cmd_bad;

    assign in_byte = {data_s, shift_q};

    always_comb begin
        rd_byte = 8'h00;
        if (is_ram_q) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                if (addr_q == 5'(i)) rd_byte = ram_q[i];
            end
        end else if (addr_q < 5'd8) begin
            rd_byte = clk_q[addr_q[2:0]];
        end
    end

    assign last_byte = is_ram_q ? (addr_q == RAM_LAST) : (addr_q == 5'd7);

    // Write protect blocks everything except register 7 itself, so WP can be cleared.
    assign wr_ok = (is_ram_q || (addr_q < 5'd8)) &&
                   (!clk_q[7][7] || (!is_ram_q && (addr_q == 5'd7)));

    assign cmd_bad = !in_byte[7] ||
                     (in_byte[6] && (in_byte[5:1] != BURST_ADDR) &&
                      ({1'b0, in_byte[5:1]} >= RAM_DEPTH_W));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        is_ram_d  = is_ram_q;
        burst_d   = burst_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        wr_stb_d  = 1'b0;
        wr_ram_d  = wr_ram_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cmd_err_d = 1'b0;
        we        = 1'b0;
        // A CE rise only counts once CE has been seen low after reset has settled.
        armed_d   = armed_q | (settle_q[SYNC_STAGES] & ~ce_s);

        if (ce_fall) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ce_rise && armed_q) begin
                        state_d   = CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_d   = in_byte[7:1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            is_ram_d  = in_byte[6];
                            burst_d   = (in_byte[5:1] == BURST_ADDR);
                            addr_d    = (in_byte[5:1] == BURST_ADDR) ? 5'd0 : in_byte[5:1];
                            if (cmd_bad) begin
                                cmd_err_d = 1'b1;
                                state_d   = DONE;
                            end else begin
                                state_d = in_byte[0] ? RDATA : WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shift_d   = in_byte[7:1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (wr_ok) begin
                                we        = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_ram_d  = is_ram_q;
                                wr_addr_d = addr_q;
                                wr_data_d = in_byte;
                            end
                            if (burst_q && !last_byte) addr_d  = addr_q + 5'd1;
                            else                       state_d = DONE;
                        end
                    end
                end
                RDATA: begin
                    // Falls drive the bit indexed by the number of rises already seen.
                    if (sclk_fall) begin
                        dout_d = rd_byte[bit_cnt_q];
                        oe_d   = 1'b1;
                    end else if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (burst_q && !last_byte) begin
                                addr_d = addr_q + 5'd1;
                            end else begin
                                oe_d    = 1'b0;
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCKINPUT) begin
        if (!PLD_RESET_N) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            is_ram_q  <= 1'b0;
            burst_q   <= 1'b0;
            addr_q    <= 5'd0;
            armed_q   <= 1'b0;
            dout_q    <= 1'b0;
            oe_q      <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_ram_q  <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 8'h00;
            cmd_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            is_ram_q  <= is_ram_d;
            burst_q   <= burst_d;
            addr_q    <= addr_d;
            armed_q   <= armed_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            wr_stb_q  <= wr_stb_d;
            wr_ram_q  <= wr_ram_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cmd_err_q <= cmd_err_d;
            busy_q    <= ce_s;
        end
    end

    always_ff @(posedge CLOCKINPUT) begin
        if (!PLD_RESET_N) begin
            for (int i = 0; i < 8; i++) clk_q[i] <= 8'h00;
            for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
        end else if (we) begin
            if (!is_ram_q) begin
                clk_q[addr_q[2:0]] <= in_byte;
            end else begin
                for (int i = 0; i < RAM_DEPTH; i++) begin
                    if (addr_q == 5'(i)) ram_q[i] <= in_byte;
                end
            end
        end
    end

    assign bus.rtc_data_out = dout_q;
    assign bus.rtc_data_oe  = oe_q;
    assign bus.wr_stb       = wr_stb_q;
    assign bus.wr_ram       = wr_ram_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.cmd_err      = cmd_err_q;
    assign bus.busy         = busy_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_rtc_3wire_responder.sv
// Bench for rtc_3wire_responder: directed scenarios plus random transactions
// checked against a byte-level model of the clock registers and RAM.
module tb_rtc_3wire_responder;
    localparam int RAM_DEPTH = 4;
    localparam int SYNC      = 2;
    localparam int H         = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtc_3wire_responder_if bus ();

    rtc_3wire_responder #(.RAM_DEPTH(RAM_DEPTH), .SYNC_STAGES(SYNC)) dut (
        .CLOCKINPUT (clk),
        .PLD_RESET_N(rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int oe_bad   = 0;
    logic last_oe = 1'b0;

    logic [13:0] exp_q[$];
    logic [13:0] stb_q[$];
    logic [7:0]  wbuf[$];
    logic [7:0]  rbuf[$];
    logic [7:0]  rexp[$];
    logic [7:0]  m_clk [8];
    logic [7:0]  m_ram [RAM_DEPTH];

    always @(negedge clk) if (bus.wr_stb === 1'b1) stb_q.push_back({bus.wr_ram, bus.wr_addr, bus.wr_data});
    always @(negedge clk) if (bus.cmd_err === 1'b1) err_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_read(input logic ram, input int a);
        if (ram) return (a < RAM_DEPTH) ? m_ram[a] : 8'h00;
        return (a < 8) ? m_clk[a] : 8'h00;
    endfunction

    task automatic m_write(input logic ram, input int a, input logic [7:0] d);
        logic [7:0] r7;
        r7 = m_clk[7];
        if (r7[7] && !(!ram && a == 7)) return;
        if (!ram && a >= 8) return;
        if (ram) m_ram[a] = d;
        else     m_clk[a] = d;
        exp_q.push_back({ram, 5'(a), d});
    endtask

    task automatic m_cmd(input logic [7:0] cmd, output int nread, output bit err);
        logic ram;
        int   a, n;
        bit   burst;
        ram   = cmd[6];
        a     = int'(cmd[5:1]);
        burst = (a == 31);
        n     = ram ? RAM_DEPTH : 8;
        err   = !cmd[7] || (ram && !burst && a >= RAM_DEPTH);
        nread = 0;
        rexp.delete();
        if (err) return;
        if (cmd[0]) begin
            if (burst) for (int k = 0; k < n; k++) rexp.push_back(m_read(ram, k));
            else       rexp.push_back(m_read(ram, a));
            nread = rexp.size();
        end else begin
            if (burst) begin
                for (int k = 0; k < n && k < wbuf.size(); k++) m_write(ram, k, wbuf[k]);
            end else if (wbuf.size() > 0) begin
                m_write(ram, a, wbuf[0]);
            end
        end
    endtask

    // ---------------- bus driver tasks ----------------
    task automatic ce_up();
        @(negedge clk);
        bus.rtc_reset_n = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic ce_down();
        repeat (H) @(negedge clk);
        bus.rtc_reset_n = 1'b0;
        bus.rtc_sclk    = 1'b0;
        bus.rtc_data_in = 1'b0;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rtc_data_in = b[i];
            repeat (H) @(negedge clk);
            bus.rtc_sclk = 1'b1;
            repeat (H) @(negedge clk);
            bus.rtc_sclk = 1'b0;
        end
    endtask

    task automatic recv_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            repeat (H) @(negedge clk);
            b[i] = bus.rtc_data_out;
            if (bus.rtc_data_oe !== 1'b1) oe_bad++;
            bus.rtc_sclk = 1'b1;
            repeat (H) @(negedge clk);
            last_oe = bus.rtc_data_oe;
            bus.rtc_sclk = 1'b0;
        end
    endtask

    task automatic bus_txn(input logic [7:0] cmd, input int nread);
        logic [7:0] b;
        rbuf.delete();
        oe_bad  = 0;
        last_oe = 1'b0;
        ce_up();
        send_bits(cmd, 8);
        foreach (wbuf[i]) send_bits(wbuf[i], 8);
        for (int k = 0; k < nread; k++) begin
            recv_byte(b);
            rbuf.push_back(b);
        end
        ce_down();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.rtc_reset_n = 1'b0;
        bus.rtc_sclk    = 1'b0;
        bus.rtc_data_in = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) m_clk[i] = 8'h00;
        for (int i = 0; i < RAM_DEPTH; i++) m_ram[i] = 8'h00;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.rtc_data_oe !== 1'b0 || bus.rtc_data_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_pins oe=%b out=%b want 0 0", bus.rtc_data_oe, bus.rtc_data_out);
        end
        n_checks++;
        if ({bus.wr_stb, bus.wr_ram, bus.wr_addr, bus.wr_data} !== 15'h0) begin
            n_fail++; $display("FAIL reset_wr stb=%b ram=%b addr=%h data=%h want all 0", bus.wr_stb, bus.wr_ram, bus.wr_addr, bus.wr_data);
        end
        n_checks++;
        if (bus.cmd_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_status cmd_err=%b busy=%b want 0 0", bus.cmd_err, bus.busy);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || stb_q.size() != 0) begin
            n_fail++; $display("FAIL post_reset_idle busy=%b strobes=%0d want 0 0", bus.busy, stb_q.size());
        end
    endtask

    task automatic test_single();
        int nr; bit er;
        stb_q.delete(); exp_q.delete();
        wbuf.delete(); wbuf.push_back(8'h5A);
        m_cmd(8'h84, nr, er);
        bus_txn(8'h84, 0);
        n_checks++;
        if (stb_q.size() != 1 || stb_q[0] !== {1'b0, 5'd2, 8'h5A}) begin
            n_fail++; $display("FAIL single_wr strobes=%0d first=%h want 1 %h", stb_q.size(), (stb_q.size() > 0) ? stb_q[0] : 14'h0, {1'b0, 5'd2, 8'h5A});
        end
        wbuf.delete();
        m_cmd(8'h85, nr, er);
        bus_txn(8'h85, 1);
        n_checks++;
        if (rbuf.size() != 1 || rbuf[0] !== 8'h5A) begin
            n_fail++; $display("FAIL single_rd got=%h want 5a", (rbuf.size() > 0) ? rbuf[0] : 8'hxx);
        end
        n_checks++;
        if (oe_bad != 0 || last_oe !== 1'b0) begin
            n_fail++; $display("FAIL single_rd_oe low_samples=%0d oe_after_last=%b want 0 0", oe_bad, last_oe);
        end
    endtask

    task automatic test_write_protect();
        int nr; bit er;
        stb_q.delete(); exp_q.delete();
        wbuf.delete(); wbuf.push_back(8'h80); m_cmd(8'h8E, nr, er); bus_txn(8'h8E, 0);
        wbuf.delete(); wbuf.push_back(8'h11); m_cmd(8'h80, nr, er); bus_txn(8'h80, 0);
        n_checks++;
        if (stb_q.size() != 1 || stb_q[0] !== {1'b0, 5'd7, 8'h80}) begin
            n_fail++; $display("FAIL wp_block strobes=%0d want 1 (reg7 only)", stb_q.size());
        end
        wbuf.delete(); m_cmd(8'h81, nr, er); bus_txn(8'h81, 1);
        n_checks++;
        if (rbuf.size() != 1 || rbuf[0] !== 8'h00) begin
            n_fail++; $display("FAIL wp_reg0 got=%h want 00", (rbuf.size() > 0) ? rbuf[0] : 8'hxx);
        end
        stb_q.delete();
        wbuf.delete(); wbuf.push_back(8'h00); m_cmd(8'h8E, nr, er); bus_txn(8'h8E, 0);
        wbuf.delete(); wbuf.push_back(8'h11); m_cmd(8'h80, nr, er); bus_txn(8'h80, 0);
        n_checks++;
        if (stb_q.size() != 2 || stb_q[0] !== {1'b0, 5'd7, 8'h00} || stb_q[1] !== {1'b0, 5'd0, 8'h11}) begin
            n_fail++; $display("FAIL wp_clear strobes=%0d want 2 (reg7=00, reg0=11)", stb_q.size());
        end
    endtask

    task automatic test_clock_burst();
        int nr; bit er;
        stb_q.delete(); exp_q.delete();
        wbuf.delete();
        for (int k = 0; k < 8; k++) wbuf.push_back(8'(k + 1));
        m_cmd(8'hBE, nr, er);
        bus_txn(8'hBE, 0);
        n_checks++;
        if (stb_q.size() != 8) begin
            n_fail++; $display("FAIL burst_wr_count got=%0d want 8", stb_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (stb_q[k] !== {1'b0, 5'(k), 8'(k + 1)}) begin
                    n_fail++; $display("FAIL burst_wr[%0d] got=%h want %h", k, stb_q[k], {1'b0, 5'(k), 8'(k + 1)});
                end
            end
        end
        wbuf.delete();
        m_cmd(8'hBF, nr, er);
        bus_txn(8'hBF, 8);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rbuf[k] !== 8'(k + 1)) begin
                n_fail++; $display("FAIL burst_rd[%0d] got=%h want %h", k, rbuf[k], 8'(k + 1));
            end
        end
        n_checks++;
        if (oe_bad != 0 || last_oe !== 1'b0) begin
            n_fail++; $display("FAIL burst_rd_oe low_samples=%0d oe_after_last=%b want 0 0", oe_bad, last_oe);
        end
    endtask

    task automatic test_ram_bounds();
        int nr; bit er; int e0;
        stb_q.delete(); exp_q.delete();
        e0 = err_cnt;
        wbuf.delete(); wbuf.push_back(8'h77); m_cmd(8'hCA, nr, er); bus_txn(8'hCA, 0);
        n_checks++;
        if (err_cnt - e0 != 1 || stb_q.size() != 0) begin
            n_fail++; $display("FAIL ram_oob errs=%0d strobes=%0d want 1 0", err_cnt - e0, stb_q.size());
        end
        wbuf.delete(); m_cmd(8'h44, nr, er); bus_txn(8'h44, 0);
        n_checks++;
        if (err_cnt - e0 != 2) begin
            n_fail++; $display("FAIL bit7_zero errs=%0d want 2", err_cnt - e0);
        end
        wbuf.delete(); wbuf.push_back(8'h3C); m_cmd(8'hC6, nr, er); bus_txn(8'hC6, 0);
        n_checks++;
        if (stb_q.size() != 1 || stb_q[0] !== {1'b1, 5'd3, 8'h3C}) begin
            n_fail++; $display("FAIL ram_last strobes=%0d want 1 %h", stb_q.size(), {1'b1, 5'd3, 8'h3C});
        end
        stb_q.delete();
        wbuf.delete();
        for (int k = 0; k < RAM_DEPTH + 1; k++) wbuf.push_back(8'(8'hA0 + k));
        m_cmd(8'hFE, nr, er);
        bus_txn(8'hFE, 0);
        n_checks++;
        if (stb_q.size() != RAM_DEPTH || stb_q[RAM_DEPTH-1] !== {1'b1, 5'(RAM_DEPTH - 1), 8'(8'hA0 + RAM_DEPTH - 1)}) begin
            n_fail++; $display("FAIL ram_burst_wr strobes=%0d want %0d", stb_q.size(), RAM_DEPTH);
        end
    endtask

    task automatic test_abort();
        int nr; bit er;
        logic [7:0] b;
        stb_q.delete();
        ce_up();
        send_bits(8'h80, 8);
        send_bits(8'h3C, 4);
        bus.rtc_reset_n = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rtc_data_oe !== 1'b0) begin
            n_fail++; $display("FAIL abort_wr_status busy=%b oe=%b want 0 0", bus.busy, bus.rtc_data_oe);
        end
        repeat (2 * H) @(negedge clk);
        n_checks++;
        if (stb_q.size() != 0) begin
            n_fail++; $display("FAIL abort_wr_stb strobes=%0d want 0", stb_q.size());
        end
        // CE dropped while the responder is driving read data.
        ce_up();
        send_bits(8'h81, 8);
        repeat (H) @(negedge clk);
        b[0] = bus.rtc_data_oe;
        bus.rtc_reset_n = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        n_checks++;
        if (b[0] !== 1'b1 || bus.rtc_data_oe !== 1'b0) begin
            n_fail++; $display("FAIL abort_rd_oe before=%b after=%b want 1 0", b[0], bus.rtc_data_oe);
        end
        repeat (2 * H) @(negedge clk);
        wbuf.delete(); m_cmd(8'h81, nr, er); bus_txn(8'h81, 1);
        n_checks++;
        if (rbuf.size() != 1 || rbuf[0] !== rexp[0]) begin
            n_fail++; $display("FAIL abort_storage got=%h want %h", (rbuf.size() > 0) ? rbuf[0] : 8'hxx, rexp[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int nr; bit er; int e0;
        stb_q.delete(); exp_q.delete();
        wbuf.delete(); wbuf.push_back(8'hC3); m_cmd(8'h80, nr, er); bus_txn(8'h80, 0);
        ce_up();
        send_bits(8'h81, 8);
        repeat (H) @(negedge clk);
        n_checks++;
        if (bus.rtc_data_oe !== 1'b1 || bus.rtc_data_out !== 1'b1) begin
            n_fail++; $display("FAIL mid_read_bit0 oe=%b out=%b want 1 1", bus.rtc_data_oe, bus.rtc_data_out);
        end
        bus.rtc_sclk = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rtc_data_oe !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_read oe=%b busy=%b want 0 0", bus.rtc_data_oe, bus.busy);
        end
        repeat (3) @(negedge clk);
        bus.rtc_sclk = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_clk[i] = 8'h00;
        for (int i = 0; i < RAM_DEPTH; i++) m_ram[i] = 8'h00;
        repeat (2 * H) @(negedge clk);
        // CE still high from before reset: no transaction may start without a fresh rise.
        stb_q.delete();
        e0 = err_cnt;
        send_bits(8'h80, 8);
        send_bits(8'hFF, 8);
        ce_down();
        n_checks++;
        if (stb_q.size() != 0 || err_cnt != e0) begin
            n_fail++; $display("FAIL no_fresh_rise strobes=%0d errs=%0d want 0 0", stb_q.size(), err_cnt - e0);
        end
        wbuf.delete();
        bus_txn(8'hBF, 8);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rbuf[k] !== 8'h00) begin
                n_fail++; $display("FAIL post_reset_clk[%0d] got=%h want 00", k, rbuf[k]);
            end
        end
        bus_txn(8'hFF, RAM_DEPTH);
        for (int k = 0; k < RAM_DEPTH; k++) begin
            n_checks++;
            if (rbuf[k] !== 8'h00) begin
                n_fail++; $display("FAIL post_reset_ram[%0d] got=%h want 00", k, rbuf[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            logic [7:0] cmd;
            int nr, a, cnt, e0;
            bit er;
            cmd    = 8'($urandom);
            cmd[7] = ($urandom_range(0, 9) != 0);
            a      = ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, cmd[6] ? 5 : 9));
            cmd[5:1] = 5'(a);
            wbuf.delete();
            if (!cmd[0]) begin
                cnt = (a == 31) ? ((cmd[6] ? RAM_DEPTH : 8) + int'($urandom_range(0, 1))) : 1;
                repeat (cnt) wbuf.push_back(8'($urandom));
            end
            stb_q.delete(); exp_q.delete();
            e0 = err_cnt;
            m_cmd(cmd, nr, er);
            bus_txn(cmd, nr);
            n_checks++;
            if (err_cnt - e0 != int'(er)) begin
                n_fail++; $display("FAIL rnd_err cmd=%h errs=%0d want %0d", cmd, err_cnt - e0, er);
            end
            n_checks++;
            if (stb_q != exp_q) begin
                n_fail++; $display("FAIL rnd_strobes cmd=%h got=%0d want %0d (or content differs)", cmd, stb_q.size(), exp_q.size());
            end
            n_checks++;
            if (rbuf != rexp) begin
                n_fail++; $display("FAIL rnd_read cmd=%h got_n=%0d want_n=%0d first=%h want %h", cmd, rbuf.size(), rexp.size(), (rbuf.size() > 0) ? rbuf[0] : 8'h0, (rexp.size() > 0) ? rexp[0] : 8'h0);
            end
            if (nr > 0) begin
                n_checks++;
                if (oe_bad != 0 || last_oe !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_oe cmd=%h low_samples=%0d oe_after_last=%b want 0 0", cmd, oe_bad, last_oe);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_write_protect();
        test_clock_burst();
        test_ram_bounds();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_3wire_responder.md
Name: rtc_3wire_responder

Overview:
Synthesizable responder for the 3-wire serial RTC bus. The board top drives this bus as initiator on rtc_reset_n, rtc_sclk and rtc_data_io. The block is the far end of that bus: it decodes command bytes, serves single-byte and burst reads and writes against an internal clock-register bank and a RAM bank, and reports each committed write on a strobe port. It is used as an on-chip RTC emulator and as the bus-level model in board-level simulation.

Parameters:
RAM_DEPTH, 31, number of RAM bytes; legal range 1..31.
SYNC_STAGES, 2, synchronizer flops on rtc_reset_n, rtc_sclk and rtc_data_in; minimum 2.

Ports:
CLOCKINPUT  in  1  system clock; all logic is on its rising edge.
PLD_RESET_N  in  1  reset; synchronous, active-low.
rtc_reset_n  in  1  bus chip-enable (CE); active-high, asynchronous to CLOCKINPUT.
rtc_sclk  in  1  bus serial clock; asynchronous.
rtc_data_in  in  1  bus data from the initiator.
rtc_data_out  out  1  bus data to the initiator.
rtc_data_oe  out  1  output enable; the top-level tristate drives the pad when this is 1.
wr_stb  out  1  one-cycle pulse when a write byte is committed.
wr_ram  out  1  1 = the committed byte went to RAM, 0 = it went to a clock register.
wr_addr  out  5  address of the committed byte.
wr_data  out  8  value of the committed byte.
cmd_err  out  1  one-cycle pulse when a command byte is rejected.
busy  out  1  high while the synchronized CE is high.

Behaviour:
- Synchronization: CE, SCLK and DATA each pass through SYNC_STAGES flops, then one edge-detect flop. A rise or fall is detected SYNC_STAGES+1 cycles after the pin change.
- Bus timing: SCLK high and low times must each be at least SYNC_STAGES+2 CLOCKINPUT cycles.
- Bit order: LSB first. The responder samples synchronized DATA on each detected SCLK rise.
- Command byte:
  - bit0 = RD (1 = read, 0 = write).
  - bits5:1 = address.
  - bit6 = RAM select (1 = RAM, 0 = clock registers).
  - bit7 must be 1.
- Address 5'h1F selects burst mode.
- States: IDLE, CMD, WDATA, RDATA, DONE.
  - IDLE -> CMD on a synchronized CE rise.
  - CMD: collect 8 bits.
    - If bit7 = 0, or a non-burst RAM address is >= RAM_DEPTH: pulse cmd_err, go to DONE.
    - Otherwise go to RDATA if RD = 1, else WDATA.
  - WDATA: shift 8 bits in. On the 8th rise, commit the byte:
    - update storage;
    - pulse wr_stb for 1 cycle with wr_ram/wr_addr/wr_data valid in the same cycle.
    - Single-byte access then goes to DONE. Burst increments the index and continues.
  - RDATA:
    - On the SCLK fall that follows the 8th command rise, set rtc_data_oe = 1 and drive bit0 of the addressed byte. The pin update lands 1 cycle after the detected fall.
    - Each later fall shifts out the next bit. Bytes chain in burst mode.
    - After the 8th rise of the last byte: rtc_data_oe = 0, go to DONE.
  - DONE: ignore SCLK until CE falls.
- Burst ranges:
  - Clock burst covers registers 0..7.
  - RAM burst covers RAM 0..RAM_DEPTH-1.
  - Past the last byte, go to DONE; extra bits are ignored.
- CE low, any state: the synchronized CE fall forces IDLE and rtc_data_oe = 0 in the same cycle. A partially shifted write byte is discarded with no wr_stb; bytes already committed stay.
- Write protect: clock register 7 bit7 = WP. With WP = 1, writes to every location except register 7 are discarded with no wr_stb.
  - In a clock-burst write, WP is evaluated per byte against the current register 7.
- Clock-register addresses 8..30 (non-burst): reads return 8'h00; writes are discarded with no wr_stb and no cmd_err.
- Reset (PLD_RESET_N = 0 at a clock edge):
  - all clock registers and RAM = 8'h00;
  - state IDLE;
  - rtc_data_out, rtc_data_oe, wr_stb, wr_ram, cmd_err, busy = 0;
  - wr_addr, wr_data = 0;
  - synchronizer flops cleared.
  - Reset mid-transaction aborts it. The next transaction starts only after a fresh CE rise.
- Same-cycle CE fall and SCLK edge: the CE fall wins and the edge is ignored.

Test Plan:
- Single write then read: write cmd 8'h84 with data 8'h5A -> wr_stb pulse with wr_ram = 0, wr_addr = 2, wr_data = 8'h5A. Read cmd 8'h85 -> 8 bits 0,1,0,1,1,0,1,0 on successive falls; rtc_data_oe high from the 8th command fall until the last data rise.
- Write protect: write 8'h80 to register 7, then 8'h11 to register 0 -> no wr_stb for the second write; reading register 0 returns 8'h00. Writing 8'h00 to register 7 then succeeds.
- Clock burst: write cmd 8'hBE with 8 bytes 8'h01..8'h08 -> 8 wr_stb pulses, addr 0..7. Burst read cmd 8'hBF returns 8'h01..8'h08, then rtc_data_oe = 0.
- RAM bounds with RAM_DEPTH = 4: cmd 8'hCA (RAM addr 5) -> cmd_err pulse, no strobes. Cmd 8'h44 (bit7 = 0) -> cmd_err pulse.
- Abort: CE drops after 4 data bits of a write -> no wr_stb; busy and rtc_data_oe = 0 within SYNC_STAGES+1 cycles. Storage unchanged.
- Reset mid-read: assert PLD_RESET_N = 0 during RDATA -> rtc_data_oe = 0 on the next edge; all registers read back 8'h00 afterwards.
